// File: rtl/frog_collision_ctrl.sv
// Per-frame frog/car collision scan with life counter and game-over state.
// Optional post-hit invulnerability (RECOVER state) is enabled by defining COLLISION_GRACE_EN.
module frog_collision_ctrl #(
   parameter int NUM_CARS     = 4,
   parameter int CAR_W        = 32,
   parameter int FROG_W       = 16,
   parameter int START_LIVES  = 3,
   parameter int GRACE_FRAMES = 60
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst_n,
   input  logic                    i_frame_tick,
   input  logic [NUM_CARS*10-1:0]  i_car_x_flat,
   input  logic [NUM_CARS*4-1:0]   i_car_lane_flat,
   input  logic [9:0]              i_frog_x,
   input  logic [3:0]              i_frog_lane,
   input  logic                    i_restart,
   output logic                    o_hit,
   output logic                    o_frog_reset,
   output logic [2:0]              o_lives,
   output logic                    o_game_over,
   output logic                    o_scanning
);

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      SCAN      = 2'd1,
      RECOVER   = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   generate
      if (NUM_CARS < 1 || NUM_CARS > 15 || START_LIVES < 1 || START_LIVES > 7 ||
          GRACE_FRAMES < 1) begin : g_bad_param
         $error("frog_collision_ctrl: parameter out of range");
      end
   endgenerate

   state_t     state, state_nxt;
   logic [3:0] idx, idx_nxt;
   logic [9:0] shadow_x, shadow_x_nxt;
   logic [3:0] shadow_lane, shadow_lane_nxt;
   logic [2:0] lives, lives_nxt;
   logic       hit_q, hit_nxt;
   logic [9:0] cur_x;
   logic [3:0] cur_lane;
   logic       hit_now;
   logic       last_car;

`ifdef COLLISION_GRACE_EN
   localparam int GRACE_W = $clog2(GRACE_FRAMES + 1);
   logic [GRACE_W-1:0] grace, grace_nxt;
`endif

   // Mux out the car currently addressed by the scan index.
   always_comb begin
      cur_x    = '0;
      cur_lane = '0;
      for (int k = 0; k < NUM_CARS; k++) begin
         if (idx == 4'(k)) begin
            cur_x    = i_car_x_flat[10*k +: 10];
            cur_lane = i_car_lane_flat[4*k +: 4];
         end
      end
   end

   // Spans compared at 11 bits so a car near the right edge never wraps to overlap x=0.
   assign hit_now = (cur_lane == shadow_lane) && (shadow_lane != 4'd0) &&
                    ({1'b0, shadow_x} < ({1'b0, cur_x} + 11'(CAR_W))) &&
                    ({1'b0, cur_x} < ({1'b0, shadow_x} + 11'(FROG_W)));
   assign last_car = (idx == 4'(NUM_CARS - 1));

   always_comb begin
      state_nxt       = state;
      idx_nxt         = idx;
      shadow_x_nxt    = shadow_x;
      shadow_lane_nxt = shadow_lane;
      lives_nxt       = lives;
      hit_nxt         = 1'b0;
`ifdef COLLISION_GRACE_EN
      grace_nxt       = grace;
`endif
      if (i_restart) begin
         state_nxt = PLAY;
         lives_nxt = 3'(START_LIVES);
         idx_nxt   = '0;
`ifdef COLLISION_GRACE_EN
         grace_nxt = '0;
`endif
      end else begin
         case (state)
            PLAY: begin
               if (i_frame_tick) begin
                  shadow_x_nxt    = i_frog_x;
                  shadow_lane_nxt = i_frog_lane;
                  idx_nxt         = '0;
                  state_nxt       = SCAN;
               end
            end
            SCAN: begin
               if (hit_now) begin
                  hit_nxt   = 1'b1;
                  lives_nxt = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                  idx_nxt   = '0;
                  if (lives <= 3'd1) begin
                     state_nxt = GAME_OVER;
                  end else begin
`ifdef COLLISION_GRACE_EN
                     state_nxt = RECOVER;
                     grace_nxt = GRACE_W'(GRACE_FRAMES);
`else
                     state_nxt = PLAY;
`endif
                  end
               end else if (last_car) begin
                  idx_nxt   = '0;
                  state_nxt = PLAY;
               end else begin
                  idx_nxt = idx + 4'd1;
               end
            end
`ifdef COLLISION_GRACE_EN
            RECOVER: begin
               if (grace == '0) begin
                  state_nxt = PLAY;
               end else if (i_frame_tick) begin
                  grace_nxt = grace - 1'b1;
               end
            end
`endif
            GAME_OVER: begin
               state_nxt = GAME_OVER;
            end
            default: begin
               state_nxt = PLAY;
            end
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state       <= PLAY;
         idx         <= '0;
         shadow_x    <= '0;
         shadow_lane <= '0;
         lives       <= 3'(START_LIVES);
         hit_q       <= 1'b0;
`ifdef COLLISION_GRACE_EN
         grace       <= '0;
`endif
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         shadow_x    <= shadow_x_nxt;
         shadow_lane <= shadow_lane_nxt;
         lives       <= lives_nxt;
         hit_q       <= hit_nxt;
`ifdef COLLISION_GRACE_EN
         grace       <= grace_nxt;
`endif
      end
   end

   assign o_hit        = hit_q;
   assign o_frog_reset = hit_q;
   assign o_lives      = lives;
   assign o_game_over  = (state == GAME_OVER);
   assign o_scanning   = (state == SCAN);

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Scoreboard bench for frog_collision_ctrl: stimulus queues expected hits, a monitor checks each o_hit.
module tb_frog_collision_ctrl;

   localparam int N  = 4;
   localparam int GF = 4;

   logic            i_Clk = 1'b0;
   logic            i_Rst_n = 1'b0;
   logic            i_frame_tick = 1'b0;
   logic [N*10-1:0] i_car_x_flat = '0;
   logic [N*4-1:0]  i_car_lane_flat = '0;
   logic [9:0]      i_frog_x = '0;
   logic [3:0]      i_frog_lane = '0;
   logic            i_restart = 1'b0;
   logic            o_hit, o_frog_reset, o_game_over, o_scanning;
   logic [2:0]      o_lives;

   frog_collision_ctrl #(
      .NUM_CARS(N), .CAR_W(32), .FROG_W(16), .START_LIVES(3), .GRACE_FRAMES(GF)
   ) dut (
      .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_frame_tick(i_frame_tick),
      .i_car_x_flat(i_car_x_flat), .i_car_lane_flat(i_car_lane_flat),
      .i_frog_x(i_frog_x), .i_frog_lane(i_frog_lane), .i_restart(i_restart),
      .o_hit(o_hit), .o_frog_reset(o_frog_reset), .o_lives(o_lives),
      .o_game_over(o_game_over), .o_scanning(o_scanning)
   );

   always #5 i_Clk = ~i_Clk;

   int cyc = 0;
   always @(posedge i_Clk) cyc <= cyc + 1;

   typedef struct {
      int         at_cyc;
      logic [2:0] lives;
      logic       go;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check_output(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every o_hit pulse must match the oldest queued expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge i_Clk);
         if (i_Rst_n && o_hit) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("[TB] FAIL unexpected_hit: got o_hit=1 at cycle %0d, expected none", cyc);
            end else begin
               e = sb.pop_front();
               check_output("hit_cycle", cyc, e.at_cyc);
               check_output("hit_lives", int'(o_lives), int'(e.lives));
               check_output("hit_game_over", int'(o_game_over), int'(e.go));
               check_output("hit_frog_reset", int'(o_frog_reset), 1);
            end
         end
      end
   end

   task automatic set_car(input int k, input int x, input int lane);
      i_car_x_flat[10*k +: 10]  = 10'(x);
      i_car_lane_flat[4*k +: 4] = 4'(lane);
   endtask

   task automatic park_cars();
      for (int k = 0; k < N; k++) set_car(k, 500, 5);
   endtask

   // Tick at cycle T; a hit on car k must appear at T+2+k with the given lives/game_over.
   task automatic apply_stimulus(input bit expect_hit, input int k, input int lives, input bit go);
      @(negedge i_Clk);
      i_frame_tick = 1'b1;
      if (expect_hit) sb.push_back('{at_cyc: cyc + 2 + k, lives: 3'(lives), go: go});
      @(negedge i_Clk);
      i_frame_tick = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge i_Clk);
   endtask

   task automatic drain(input string name);
      wait_cycles(10);
      check_output(name, sb.size(), 0);
      sb.delete();
   endtask

   task automatic pulse_restart();
      @(negedge i_Clk);
      i_restart = 1'b1;
      @(negedge i_Clk);
      i_restart = 1'b0;
   endtask

   task automatic clear_grace();
      park_cars();
      repeat (GF + 2) begin
         apply_stimulus(1'b0, 0, 0, 1'b0);
         wait_cycles(8);
      end
   endtask

   initial begin
      park_cars();
      i_frog_x    = 10'd100;
      i_frog_lane = 4'd2;
      wait_cycles(3);
      i_Rst_n = 1'b1;
      wait_cycles(2);

      // Reset state
      check_output("rst_lives", int'(o_lives), 3);
      check_output("rst_game_over", int'(o_game_over), 0);
      check_output("rst_hit", int'(o_hit), 0);
      check_output("rst_frog_reset", int'(o_frog_reset), 0);
      check_output("rst_scanning", int'(o_scanning), 0);

      // Car 1 overlaps the frog: hit at T+3, lives 2
      set_car(1, 90, 2);
      apply_stimulus(1'b1, 1, 2, 1'b0);
      check_output("scan_started", int'(o_scanning), 1);
`ifdef COLLISION_GRACE_EN
      wait_cycles(3);
      i_frame_tick = 1'b1;
      @(negedge i_Clk);
      i_frame_tick = 1'b0;
      check_output("recover_no_scan", int'(o_scanning), 0);
`endif
      drain("hit1_sb_empty");
      check_output("hit1_lives_after", int'(o_lives), 2);
      clear_grace();

      // Touching edges on both sides: no hit, full scan then PLAY at T+5
      set_car(0, 68, 2);
      set_car(1, 116, 2);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      check_output("edge_scan_t1", int'(o_scanning), 1);
      wait_cycles(3);
      check_output("edge_scan_t4", int'(o_scanning), 1);
      wait_cycles(1);
      check_output("edge_play_t5", int'(o_scanning), 0);
      drain("edge_sb_empty");
      check_output("edge_lives", int'(o_lives), 2);
      park_cars();

      // Three hits down to game over
      pulse_restart();
      check_output("restart_lives", int'(o_lives), 3);
      for (int i = 0; i < 3; i++) begin
         set_car(2, 100, 2);
         apply_stimulus(1'b1, 2, 2 - i, (i == 2));
         drain("multi_hit_sb_empty");
         set_car(2, 500, 5);
         if (i < 2) clear_grace();
      end
      check_output("go_level", int'(o_game_over), 1);
      check_output("go_lives", int'(o_lives), 0);
      set_car(2, 100, 2);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      check_output("go_no_scan", int'(o_scanning), 0);
      drain("go_no_hit");
      check_output("go_lives_hold", int'(o_lives), 0);
      pulse_restart();
      check_output("go_restart_lives", int'(o_lives), 3);
      check_output("go_restart_level", int'(o_game_over), 0);
      apply_stimulus(1'b1, 2, 2, 1'b0);
      drain("post_restart_hit");
      pulse_restart();
      park_cars();

      // Lane 0 is safe; a car at x=1020 must not wrap onto frog x=0
      i_frog_lane = 4'd0;
      set_car(0, 100, 0);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      drain("lane0_no_hit");
      i_frog_x    = 10'd0;
      i_frog_lane = 4'd3;
      set_car(0, 1020, 3);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      drain("no_wrap_no_hit");
      check_output("safe_lives", int'(o_lives), 3);
      park_cars();
      i_frog_x    = 10'd100;
      i_frog_lane = 4'd2;

      // Restart in the very cycle car 1 is tested
      set_car(1, 90, 2);
      @(negedge i_Clk);
      i_frame_tick = 1'b1;
      @(negedge i_Clk);
      i_frame_tick = 1'b0;
      @(negedge i_Clk);
      i_restart = 1'b1;
      @(negedge i_Clk);
      i_restart = 1'b0;
      check_output("restart_prio_scanning", int'(o_scanning), 0);
      drain("restart_prio_no_hit");
      check_output("restart_prio_lives", int'(o_lives), 3);

      // Asynchronous reset mid-scan after losing a life
      apply_stimulus(1'b1, 1, 2, 1'b0);
      drain("pre_reset_hit");
      clear_grace();
      check_output("pre_reset_lives", int'(o_lives), 2);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      #2;
      i_Rst_n = 1'b0;
      #1;
      check_output("async_rst_scanning", int'(o_scanning), 0);
      check_output("async_rst_lives", int'(o_lives), 3);
      check_output("async_rst_hit", int'(o_hit), 0);
      check_output("async_rst_game_over", int'(o_game_over), 0);
      @(negedge i_Clk);
      i_Rst_n = 1'b1;
      wait_cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
